// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
//
// On-chip word memory that plays the target side of the LC-3 SRAM bus. It
// answers the active-low strobes (CE/UB/LB/OE/WE) coming from the control
// unit with the same 2-cycle read/write timing as the external SRAM. Read
// data is valid before the controller latches MDR. A write commits only once
// WE has been held at one address for WRITE_LAT consecutive edges. A preload
// port fills program memory while the bus is idle.
//
// Ports
//   Clk            in   system clock, rising edge
//   Reset_n        in   asynchronous active-low reset
//   ADDR           in   word address (from MAR)
//   Data_to_mem    in   write data (from MDR)
//   Data_from_mem  out  registered read data, holds outside read windows
//   Mem_CE         in   chip enable, active low
//   Mem_UB         in   upper byte lane [15:8] enable, active low
//   Mem_LB         in   lower byte lane [7:0] enable, active low
//   Mem_OE         in   output enable (read), active low
//   Mem_WE         in   write enable, active low
//   Rd_valid       out  Data_from_mem holds data for the current read window
//   Wr_done        out  one-cycle pulse in the cycle after a write commits
//   Conflict       out  sticky flag: OE and WE were sampled active together
//   Init_we        in   preload request, held by the requester until acked
//   Init_addr      in   preload address
//   Init_data      in   preload data (both lanes written)
//   Init_ack       out  one-cycle pulse: preload accepted on previous edge
// ---------------------------------------------------------------------------
module sram_responder #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] Data_to_mem,
    output logic [DATA_W-1:0] Data_from_mem,
    input  logic              Mem_CE,
    input  logic              Mem_UB,
    input  logic              Mem_LB,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    output logic              Rd_valid,
    output logic              Wr_done,
    output logic              Conflict,
    input  logic              Init_we,
    input  logic [ADDR_W-1:0] Init_addr,
    input  logic [DATA_W-1:0] Init_data,
    output logic              Init_ack
);

    localparam int          DEPTH  = 1 << ADDR_W;
    localparam int          HALF   = DATA_W / 2;
    localparam logic [2:0]  WR_CNT = 3'(WRITE_LAT);
    localparam logic [2:0]  RD_CNT = 3'(READ_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_HOLD,
        S_WR_WAIT,
        S_WR_HOLD
    } state_t;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dataOut;
    logic              r_rdValid;
    logic              r_wrDone;
    logic              r_conflict;
    logic              r_initAck;

    logic              w_sel;
    logic              w_wrReq;
    logic              w_rdReq;
    logic              w_sameAddr;
    logic              w_wrHoldSame;
    logic [2:0]        w_cntInc;
    logic [2:0]        w_nextCnt;
    state_t            w_nextState;
    logic              w_commit;
    logic              w_rdLoad;
    logic              w_preload;
    logic [1:0]        w_laneWe;
    logic [ADDR_W-1:0] w_memAddr;
    logic [DATA_W-1:0] w_memData;
    logic [DATA_W-1:0] w_rdWord;
    logic [DATA_W-1:0] w_rdData;

    // Bus decode and next-state computation. WE wins over OE, so a cycle
    // with both strobes low is treated as a write (and flagged separately).
    // The window counter restarts whenever the operation kind changes or the
    // address moves, so a write only commits after WRITE_LAT stable edges.
    // Once a write window has committed, WR_HOLD swallows further edges at the
    // same address so each window produces exactly one commit.
    always_comb begin
        w_sel        = ~Mem_CE & (~Mem_UB | ~Mem_LB);
        w_wrReq      = w_sel & ~Mem_WE;
        w_rdReq      = w_sel & ~Mem_OE & Mem_WE;
        w_sameAddr   = (ADDR == r_addr);
        w_wrHoldSame = (r_state == S_WR_HOLD) && w_sameAddr;
        w_cntInc     = (r_cnt == 3'd7) ? 3'd7 : r_cnt + 3'd1;

        w_nextCnt = 3'd0;
        if (w_wrReq) begin
            w_nextCnt = (((r_state == S_WR_WAIT) || (r_state == S_WR_HOLD)) && w_sameAddr)
                        ? w_cntInc : 3'd1;
        end else if (w_rdReq) begin
            w_nextCnt = (((r_state == S_RD_WAIT) || (r_state == S_RD_HOLD)) && w_sameAddr)
                        ? w_cntInc : 3'd1;
        end

        w_commit = w_wrReq && !w_wrHoldSame && (w_nextCnt == WR_CNT);
        w_rdLoad = w_rdReq && (((r_state == S_RD_HOLD) && w_sameAddr) || (w_nextCnt == RD_CNT));

        w_nextState = S_IDLE;
        if (w_wrReq) begin
            w_nextState = (w_commit || w_wrHoldSame) ? S_WR_HOLD : S_WR_WAIT;
        end else if (w_rdReq) begin
            w_nextState = w_rdLoad ? S_RD_HOLD : S_RD_WAIT;
        end

        // Preload only slips in when the bus is quiet on both sides of the edge.
        w_preload = Init_we && (r_state == S_IDLE) && (w_nextState == S_IDLE);
    end

    // Single memory write port shared by bus commits and preloads. The two can
    // never coincide because a commit always leaves the FSM outside IDLE.
    always_comb begin
        w_laneWe  = 2'b00;
        w_memAddr = ADDR;
        w_memData = Data_to_mem;
        if (w_commit) begin
            w_laneWe = {~Mem_UB, ~Mem_LB};
        end else if (w_preload) begin
            w_laneWe  = 2'b11;
            w_memAddr = Init_addr;
            w_memData = Init_data;
        end
    end

    // Read data with disabled lanes forced to zero, as seen on the real bus.
    always_comb begin
        w_rdWord = r_mem[ADDR];
        w_rdData = {(~Mem_UB ? w_rdWord[DATA_W-1:HALF] : {HALF{1'b0}}),
                    (~Mem_LB ? w_rdWord[HALF-1:0]      : {HALF{1'b0}})};
    end

    // Storage array. Deliberately not reset so preloaded programs survive a
    // reset pulse; a write interrupted by reset simply never reaches here.
    always_ff @(posedge Clk) begin
        if (w_laneWe[1]) begin
            r_mem[w_memAddr][DATA_W-1:HALF] <= w_memData[DATA_W-1:HALF];
        end
        if (w_laneWe[0]) begin
            r_mem[w_memAddr][HALF-1:0] <= w_memData[HALF-1:0];
        end
    end

    // Bus FSM with registered outputs. Read data is reloaded on every edge of
    // RD_HOLD so it follows any change of the underlying word. The address is
    // latched on every active edge; an unchanged address leaves it as is and a
    // changed one restarts the window, so this is the same as latching on entry.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_addr     <= '0;
            r_dataOut  <= '0;
            r_rdValid  <= 1'b0;
            r_wrDone   <= 1'b0;
            r_conflict <= 1'b0;
            r_initAck  <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_cnt     <= w_nextCnt;
            r_rdValid <= w_rdLoad;
            r_wrDone  <= w_commit;
            r_initAck <= w_preload;
            if (w_wrReq || w_rdReq) begin
                r_addr <= ADDR;
            end
            if (w_rdLoad) begin
                r_dataOut <= w_rdData;
            end
            if (w_wrReq && ~Mem_OE) begin
                r_conflict <= 1'b1;
            end
        end
    end

    assign Data_from_mem = r_dataOut;
    assign Rd_valid      = r_rdValid;
    assign Wr_done       = r_wrDone;
    assign Conflict      = r_conflict;
    assign Init_ack      = r_initAck;

endmodule

// File: tb/tb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_responder
//
// Directed scenarios for preload, reads, writes, byte lanes, conflicts,
// address changes and reset, followed by randomized bus traffic. A reference
// model tracks memory contents and bus windows and queues the expected
// Rd_valid/Wr_done/Init_ack events with the cycle they should appear in; a
// separate monitor pops and compares whenever the DUT presents one.
// ---------------------------------------------------------------------------
module tb_sram_responder;

    localparam int READ_LAT  = 2;
    localparam int WRITE_LAT = 2;

    logic        Clk;
    logic        Reset_n;
    logic        busCe, busUb, busLb, busOe, busWe;
    logic [9:0]  busAddr;
    logic [15:0] busData;
    logic        initWe;
    logic [9:0]  initAddr;
    logic [15:0] initData;
    logic [15:0] dataOut;
    logic        rdValid, wrDone, conflict, initAck;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit monOn  = 0;

    typedef struct packed {
        int          cyc;
        logic [15:0] data;
    } rdExp_t;

    rdExp_t rdQ[$];
    int     wrQ[$];
    int     ackQ[$];

    // Reference model state
    logic [15:0] modelMem [0:1023];
    int          winKind;
    logic [9:0]  winAddr;
    int          winLen;
    bit          winCommitted;
    bit          prevActive;
    bit          modelConflict;
    bit          lastPreloadAccepted;

    sram_responder #(
        .ADDR_W   (10),
        .DATA_W   (16),
        .READ_LAT (READ_LAT),
        .WRITE_LAT(WRITE_LAT)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .ADDR         (busAddr),
        .Data_to_mem  (busData),
        .Data_from_mem(dataOut),
        .Mem_CE       (busCe),
        .Mem_UB       (busUb),
        .Mem_LB       (busLb),
        .Mem_OE       (busOe),
        .Mem_WE       (busWe),
        .Rd_valid     (rdValid),
        .Wr_done      (wrDone),
        .Conflict     (conflict),
        .Init_we      (initWe),
        .Init_addr    (initAddr),
        .Init_data    (initData),
        .Init_ack     (initAck)
    );

    // Free-running clock and edge counter
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Hard stop in case the stimulus ever stalls
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model of one rising edge, in terms of bus windows: count
    // consecutive edges of the same operation at the same address.
    task automatic modelEdge();
        bit          sel;
        bit          active;
        int          kind;
        rdExp_t      e;
        logic [15:0] w;
        sel    = !busCe && (!busUb || !busLb);
        active = sel && (!busOe || !busWe);
        lastPreloadAccepted = 0;
        if (!active) begin
            if (initWe && !prevActive) begin
                modelMem[initAddr] = initData;
                ackQ.push_back(cyc);
                lastPreloadAccepted = 1;
            end
            winKind = 0;
            winLen  = 0;
        end else begin
            kind = !busWe ? 2 : 1;
            if (kind == winKind && busAddr == winAddr) begin
                winLen++;
            end else begin
                winKind      = kind;
                winAddr      = busAddr;
                winLen       = 1;
                winCommitted = 0;
            end
            if (kind == 2) begin
                if (!busOe) modelConflict = 1;
                if (!winCommitted && winLen == WRITE_LAT) begin
                    if (!busUb) modelMem[busAddr][15:8] = busData[15:8];
                    if (!busLb) modelMem[busAddr][7:0]  = busData[7:0];
                    wrQ.push_back(cyc);
                    winCommitted = 1;
                end
            end else if (winLen >= READ_LAT - 1) begin
                w = modelMem[busAddr];
                e.cyc  = cyc;
                e.data = {(!busUb ? w[15:8] : 8'h00), (!busLb ? w[7:0] : 8'h00)};
                rdQ.push_back(e);
            end
        end
        prevActive = active;
    endtask

    // Drive one bus cycle, let the edge sample it, then advance the model
    task automatic applyStimulus(input logic ce, input logic ub, input logic lb,
                                 input logic oe, input logic we,
                                 input logic [9:0] addr, input logic [15:0] data);
        busCe = ce; busUb = ub; busLb = lb; busOe = oe; busWe = we;
        busAddr = addr; busData = data;
        @(posedge Clk);
        #1;
        if (Reset_n) begin
            modelEdge();
            if (lastPreloadAccepted) initWe = 1'b0;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 1, 1, 1, 1, 10'h000, 16'h0000);
    endtask

    task automatic requestPreload(input logic [9:0] a, input logic [15:0] d);
        initWe = 1'b1; initAddr = a; initData = d;
    endtask

    task automatic preloadWord(input logic [9:0] a, input logic [15:0] d);
        requestPreload(a, d);
        for (int k = 0; k < 4 && initWe; k++) idleCycles(1);
    endtask

    task automatic readWord(input logic [9:0] a, input logic ub, input logic lb,
                            input logic [15:0] exp, input string name);
        for (int i = 0; i < READ_LAT; i++) begin
            applyStimulus(0, ub, lb, 0, 1, a, 16'h0000);
            if (i == READ_LAT - 2) begin
                checkOutput({name, " valid"}, rdValid, 1);
                checkOutput({name, " data"}, dataOut, exp);
            end
        end
        idleCycles(1);
    endtask

    task automatic writeWord(input logic [9:0] a, input logic [15:0] d, input logic ub,
                             input logic lb, input logic oe, input int len);
        for (int i = 0; i < len; i++) applyStimulus(0, ub, lb, oe, 0, a, d);
        idleCycles(1);
    endtask

    // Reset begins asynchronously mid-cycle; expectations pending in the
    // scoreboard are dropped along with the DUT state.
    task automatic startReset();
        Reset_n = 1'b0;
        rdQ.delete(); wrQ.delete(); ackQ.delete();
        winKind = 0; winLen = 0; prevActive = 0; modelConflict = 0;
        initWe = 1'b0;
    endtask

    task automatic endReset();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    // Monitor: compares every presented event against the queue heads
    always @(negedge Clk) begin
        if (monOn && Reset_n) begin
            if (rdValid || (rdQ.size() > 0 && rdQ[0].cyc == cyc)) begin
                checks++;
                if (rdQ.size() == 0 || rdQ[0].cyc != cyc) begin
                    errors++;
                    $display("[TB] FAIL rd_event cyc=%0d: got Rd_valid=%b data=%h, expected no read", cyc, rdValid, dataOut);
                end else begin
                    if (!rdValid || dataOut !== rdQ[0].data) begin
                        errors++;
                        $display("[TB] FAIL rd_event cyc=%0d: got Rd_valid=%b data=%h, expected Rd_valid=1 data=%h",
                                 cyc, rdValid, dataOut, rdQ[0].data);
                    end
                    void'(rdQ.pop_front());
                end
            end
            if (wrDone || (wrQ.size() > 0 && wrQ[0] == cyc)) begin
                checks++;
                if (wrQ.size() == 0 || wrQ[0] != cyc || !wrDone) begin
                    errors++;
                    $display("[TB] FAIL wr_done cyc=%0d: got Wr_done=%b, expected %b", cyc, wrDone, !wrDone);
                end
                if (wrQ.size() > 0 && wrQ[0] == cyc) void'(wrQ.pop_front());
            end
            if (initAck || (ackQ.size() > 0 && ackQ[0] == cyc)) begin
                checks++;
                if (ackQ.size() == 0 || ackQ[0] != cyc || !initAck) begin
                    errors++;
                    $display("[TB] FAIL init_ack cyc=%0d: got Init_ack=%b, expected %b", cyc, initAck, !initAck);
                end
                if (ackQ.size() > 0 && ackQ[0] == cyc) void'(ackQ.pop_front());
            end
            checks++;
            if (conflict !== modelConflict) begin
                errors++;
                $display("[TB] FAIL conflict cyc=%0d: got %b, expected %b", cyc, conflict, modelConflict);
            end
        end
    end

    initial begin
        logic [9:0]  ra, ra2;
        logic [15:0] rd;
        logic        rub, rlb, roe;
        int          rlen, rsel;
        logic [1:0]  expAck [0:4];
        logic [1:0]  expWr  [0:4];

        busCe = 1; busUb = 1; busLb = 1; busOe = 1; busWe = 1;
        busAddr = '0; busData = '0;
        initWe = 0; initAddr = '0; initData = '0;
        winKind = 0; winLen = 0; winAddr = '0; winCommitted = 0;
        prevActive = 0; modelConflict = 0; lastPreloadAccepted = 0;
        Reset_n = 1'b1;
        #1 Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("reset Data_from_mem", dataOut, 0);
        checkOutput("reset Rd_valid", rdValid, 0);
        checkOutput("reset Wr_done", wrDone, 0);
        checkOutput("reset Conflict", conflict, 0);
        checkOutput("reset Init_ack", initAck, 0);
        Reset_n = 1'b1;
        monOn = 1;
        idleCycles(1);

        // T1: preload then 2-cycle read
        requestPreload(10'h005, 16'hBEEF);
        idleCycles(1);
        checkOutput("T1 Init_ack", initAck, 1);
        idleCycles(1);
        checkOutput("T1 Init_ack pulse end", initAck, 0);
        readWord(10'h005, 0, 0, 16'hBEEF, "T1 read");

        // T2: full write, then a too-short write that must not commit
        applyStimulus(0, 0, 0, 1, 0, 10'h010, 16'h1234);
        applyStimulus(0, 0, 0, 1, 0, 10'h010, 16'h1234);
        checkOutput("T2 Wr_done", wrDone, 1);
        idleCycles(1);
        checkOutput("T2 Wr_done pulse end", wrDone, 0);
        readWord(10'h010, 0, 0, 16'h1234, "T2 readback");
        applyStimulus(0, 0, 0, 1, 0, 10'h010, 16'h5555);
        checkOutput("T2 short write Wr_done", wrDone, 0);
        idleCycles(1);
        checkOutput("T2 short write Wr_done late", wrDone, 0);
        readWord(10'h010, 0, 0, 16'h1234, "T2 short readback");

        // T3: lower-lane write and lane-masked reads
        writeWord(10'h010, 16'hABCD, 1, 0, 1, 2);
        readWord(10'h010, 1, 0, 16'h00CD, "T3 lower lane read");
        readWord(10'h010, 0, 0, 16'h12CD, "T3 full read");

        // T4: OE and WE together: write wins, Conflict sticks until reset
        applyStimulus(0, 0, 0, 0, 0, 10'h020, 16'h0F0F);
        checkOutput("T4 Conflict set", conflict, 1);
        applyStimulus(0, 0, 0, 0, 0, 10'h020, 16'h0F0F);
        idleCycles(3);
        checkOutput("T4 Conflict sticky", conflict, 1);
        readWord(10'h020, 0, 0, 16'h0F0F, "T4 readback");
        startReset();
        #1;
        checkOutput("T4 Conflict cleared", conflict, 0);
        endReset();
        idleCycles(1);

        // T5: address change restarts the window; preload waits for IDLE
        preloadWord(10'h030, 16'h3030);
        requestPreload(10'h040, 16'h4444);
        expAck = '{0, 0, 0, 0, 1};
        expWr  = '{0, 0, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      applyStimulus(0, 0, 0, 1, 0, 10'h030, 16'h7777);
            else if (i < 3)  applyStimulus(0, 0, 0, 1, 0, 10'h031, 16'h7777);
            else             applyStimulus(1, 1, 1, 1, 1, 10'h000, 16'h0000);
            checkOutput($sformatf("T5 Init_ack edge%0d", i + 1), initAck, 32'(expAck[i]));
            checkOutput($sformatf("T5 Wr_done edge%0d", i + 1), wrDone, 32'(expWr[i]));
        end
        readWord(10'h030, 0, 0, 16'h3030, "T5 old addr");
        readWord(10'h031, 0, 0, 16'h7777, "T5 new addr");
        readWord(10'h040, 0, 0, 16'h4444, "T5 preload");

        // T6: reset in the middle of a write window
        preloadWord(10'h050, 16'h5A5A);
        preloadWord(10'h060, 16'h6666);
        readWord(10'h050, 0, 0, 16'h5A5A, "T6 pre read");
        applyStimulus(0, 0, 0, 0, 0, 10'h060, 16'h9999);
        checkOutput("T6 Conflict before reset", conflict, 1);
        startReset();
        #1;
        checkOutput("T6 async Data_from_mem", dataOut, 0);
        checkOutput("T6 async Rd_valid", rdValid, 0);
        checkOutput("T6 async Wr_done", wrDone, 0);
        checkOutput("T6 async Conflict", conflict, 0);
        checkOutput("T6 async Init_ack", initAck, 0);
        endReset();
        idleCycles(1);
        readWord(10'h060, 0, 0, 16'h6666, "T6 target unchanged");
        readWord(10'h050, 0, 0, 16'h5A5A, "T6 preload survives");

        // Randomized traffic over a preloaded region
        for (int a = 0; a < 16; a++) preloadWord(10'h100 + 10'(a), 16'($urandom));
        for (int t = 0; t < 400; t++) begin
            ra   = 10'h100 + 10'($urandom_range(0, 15));
            ra2  = 10'h100 + 10'($urandom_range(0, 15));
            rd   = 16'($urandom);
            rub  = 1'($urandom_range(0, 1));
            rlb  = 1'($urandom_range(0, 1));
            rlen = $urandom_range(1, 3);
            rsel = $urandom_range(0, 99);
            if (!initWe && $urandom_range(0, 3) == 0)
                requestPreload(10'h100 + 10'($urandom_range(0, 15)), 16'($urandom));
            if (rsel < 40) begin
                for (int i = 0; i < rlen; i++) applyStimulus(0, rub, rlb, 0, 1, ra, 16'h0000);
            end else if (rsel < 80) begin
                roe = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
                for (int i = 0; i < rlen; i++)
                    applyStimulus(0, rub, rlb, roe, 0, (rlen == 3 && i > 0 && rsel[0]) ? ra2 : ra, rd);
            end else begin
                idleCycles(rlen);
            end
            idleCycles($urandom_range(0, 1));
        end
        for (int k = 0; k < 4 && initWe; k++) idleCycles(1);
        idleCycles(2);

        checkOutput("final read queue drained", rdQ.size(), 0);
        checkOutput("final write queue drained", wrQ.size(), 0);
        checkOutput("final ack queue drained", ackQ.size(), 0);
        monOn = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
